// File: rtl/tile_input_buffer_pkg.sv
// rtl/tile_input_buffer_pkg.sv - shared types and derived sizing for the tile input buffer
package tile_input_buffer_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOAD   = 2'd1,
      STREAM = 2'd2
   } state_e;

   function automatic int storage_depth(input int n, input int max_len);
      return n * max_len;
   endfunction

   // Sized for the largest length the field can encode, so malformed lengths cannot wrap the counter.
   function automatic int req_cnt_bits(input int n, input int len_bits, input int p);
      return $clog2((n * ((1 << len_bits) - 1)) / p + 1);
   endfunction

endpackage

// File: rtl/tile_input_buffer_storage.sv
// rtl/tile_input_buffer_storage.sv - N row register arrays, P-wide flat-index write, column read
module tile_storage #(
   parameter int DATA_WIDTH  = 8,
   parameter int N           = 4,
   parameter int P           = 4,
   parameter int MAX_LEN     = 64,
   parameter int IDX_BITS    = 9,
   parameter int LENGTH_BITS = 7
) (
   input  logic                    clk,
   input  logic                    wr_en,
   input  logic [IDX_BITS-1:0]     wr_idx,
   input  logic [LENGTH_BITS-1:0]  wr_len,
   input  logic [P*DATA_WIDTH-1:0] wr_data,
   input  logic [LENGTH_BITS-1:0]  rd_col,
   output logic [N*DATA_WIDTH-1:0] rd_data
);
   localparam int ROW_BITS = (N > 1) ? $clog2(N) : 1;
   localparam int COL_BITS = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

   logic [DATA_WIDTH-1:0] mem_q [N][MAX_LEN];
   logic [DATA_WIDTH-1:0] mem_d [N][MAX_LEN];

   // Row is found by comparing against multiples of L rather than dividing.
   always_comb begin
      int fi;
      int row;
      int col;
      logic [ROW_BITS-1:0] row_sel;
      logic [COL_BITS-1:0] col_sel;
      fi      = 0;
      row     = 0;
      col     = 0;
      row_sel = '0;
      col_sel = '0;
      mem_d   = mem_q;
      if (wr_en) begin
         for (int e = 0; e < P; e++) begin
            fi  = int'(wr_idx) + e;
            row = 0;
            for (int r = 1; r < N; r++) begin
               if (fi >= r * int'(wr_len)) row = r;
            end
            col     = fi - row * int'(wr_len);
            row_sel = ROW_BITS'(row);
            col_sel = COL_BITS'(col);
            if (col < MAX_LEN) mem_d[row_sel][col_sel] = wr_data[e*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   always_comb begin
      rd_data = '0;
      if (int'(rd_col) < MAX_LEN) begin
         for (int r = 0; r < N; r++) begin
            rd_data[r*DATA_WIDTH +: DATA_WIDTH] = mem_q[ROW_BITS'(r)][rd_col[COL_BITS-1:0]];
         end
      end
   end

endmodule

// File: rtl/tile_input_buffer.sv
// rtl/tile_input_buffer.sv - loads an N x L operand tile from memory and replays it as N-wide columns R times
// Optional INPUT_BUFFER_FORMAT_CHECK_EN: drop misaligned/oversized instructions and raise sticky error.
module tile_input_buffer
   import tile_input_buffer_pkg::*;
#(
   parameter int DATA_WIDTH                   = 8,
   parameter int N                            = 4,
   parameter int MAX_MATRIX_LENGTH            = 64,
   parameter int PARALLEL_DATA_STREAMING_SIZE = 4,
   parameter int MEMORY_ADDRESS_BITS          = 64,
   parameter int LENGTH_BITS                  = $clog2(MAX_MATRIX_LENGTH + 1),
   parameter int REPEATS_BITS                 = $clog2(MAX_MATRIX_LENGTH / N + 1)
) (
   input  logic                                         clk,
   input  logic                                         reset,
   input  logic                                         instruction_valid,
   output logic                                         instruction_ready,
   input  logic [MEMORY_ADDRESS_BITS-1:0]               address_input,
   input  logic [LENGTH_BITS-1:0]                       length_input,
   input  logic [REPEATS_BITS-1:0]                      repeats_input,
   output logic                                         mem_req_valid,
   input  logic                                         mem_req_ready,
   output logic [MEMORY_ADDRESS_BITS-1:0]               mem_req_addr,
   input  logic                                         mem_resp_valid,
   input  logic [PARALLEL_DATA_STREAMING_SIZE*DATA_WIDTH-1:0] mem_resp_data,
   output logic                                         out_valid,
   input  logic                                         out_ready,
   output logic [N*DATA_WIDTH-1:0]                      out_data,
   output logic                                         out_last,
   output logic                                         error
);
   localparam int P        = PARALLEL_DATA_STREAMING_SIZE;
   localparam int RCB      = req_cnt_bits(N, LENGTH_BITS, P);
   localparam int IDX_BITS = RCB + $clog2(P);

   state_e                         state_q, state_d;
   logic [MEMORY_ADDRESS_BITS-1:0] base_q, base_d;
   logic [LENGTH_BITS-1:0]         len_q, len_d, col_q, col_d;
   logic [REPEATS_BITS-1:0]        rep_q, rep_d, pass_q, pass_d;
   logic [RCB-1:0]                 req_cnt_q, req_cnt_d, resp_cnt_q, resp_cnt_d;
   logic                           error_q, error_d;
   logic [RCB-1:0]                 total_req;
   logic                           fmt_bad;
   logic                           wr_en;
   logic [N*DATA_WIDTH-1:0]        col_data;

   assign total_req = RCB'((N * int'(len_q)) / P);

`ifdef INPUT_BUFFER_FORMAT_CHECK_EN
   assign fmt_bad = ((address_input % MEMORY_ADDRESS_BITS'(P)) != '0) ||
                    ((int'(length_input) % P) != 0) ||
                    (int'(length_input) > MAX_MATRIX_LENGTH);
`else
   assign fmt_bad = 1'b0;
`endif

   always_comb begin
      state_d       = state_q;
      base_d        = base_q;
      len_d         = len_q;
      rep_d         = rep_q;
      col_d         = col_q;
      pass_d        = pass_q;
      req_cnt_d     = req_cnt_q;
      resp_cnt_d    = resp_cnt_q;
      error_d       = error_q;
      mem_req_valid = 1'b0;
      out_valid     = 1'b0;
      wr_en         = 1'b0;
      case (state_q)
         IDLE: begin
            if (instruction_valid) begin
               base_d     = address_input;
               len_d      = length_input;
               rep_d      = repeats_input;
               req_cnt_d  = '0;
               resp_cnt_d = '0;
               col_d      = '0;
               pass_d     = '0;
               if (fmt_bad) error_d = 1'b1;
               else if (length_input != '0 && repeats_input != '0) state_d = LOAD;
            end
         end
         LOAD: begin
            mem_req_valid = (req_cnt_q != total_req);
            if (mem_req_valid && mem_req_ready) req_cnt_d = req_cnt_q + RCB'(1);
            if (mem_resp_valid) begin
               wr_en      = 1'b1;
               resp_cnt_d = resp_cnt_q + RCB'(1);
               if (resp_cnt_q == total_req - RCB'(1)) state_d = STREAM;
            end
            // Only reachable when N*L < P; avoids waiting forever for a response that never comes.
            if (total_req == '0) state_d = STREAM;
         end
         STREAM: begin
            out_valid = 1'b1;
            if (out_ready) begin
               if (col_q == len_q - LENGTH_BITS'(1)) begin
                  col_d = '0;
                  if (pass_q == rep_q - REPEATS_BITS'(1)) state_d = IDLE;
                  else pass_d = pass_q + REPEATS_BITS'(1);
               end else begin
                  col_d = col_q + LENGTH_BITS'(1);
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         base_q     <= '0;
         len_q      <= '0;
         rep_q      <= '0;
         col_q      <= '0;
         pass_q     <= '0;
         req_cnt_q  <= '0;
         resp_cnt_q <= '0;
         error_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         base_q     <= base_d;
         len_q      <= len_d;
         rep_q      <= rep_d;
         col_q      <= col_d;
         pass_q     <= pass_d;
         req_cnt_q  <= req_cnt_d;
         resp_cnt_q <= resp_cnt_d;
         error_q    <= error_d;
      end
   end

   tile_storage #(
      .DATA_WIDTH  (DATA_WIDTH),
      .N           (N),
      .P           (P),
      .MAX_LEN     (MAX_MATRIX_LENGTH),
      .IDX_BITS    (IDX_BITS),
      .LENGTH_BITS (LENGTH_BITS)
   ) u_storage (
      .clk     (clk),
      .wr_en   (wr_en),
      .wr_idx  (IDX_BITS'(resp_cnt_q) * IDX_BITS'(P)),
      .wr_len  (len_q),
      .wr_data (mem_resp_data),
      .rd_col  (col_q),
      .rd_data (col_data)
   );

   assign instruction_ready = (state_q == IDLE) && !reset;
   assign mem_req_addr      = base_q + MEMORY_ADDRESS_BITS'(req_cnt_q) * MEMORY_ADDRESS_BITS'(P);
   assign out_data          = (state_q == STREAM) ? col_data : '0;
   assign out_last          = (state_q == STREAM) && (col_q == len_q - LENGTH_BITS'(1));
   assign error             = error_q;

endmodule
